player_mover: RTL and testbench
===============================

PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 The block SHALL have parameter NPLAYERS, default 2, number of players (1..4).
REQ-002 The block SHALL have parameter HACTIVE, default 800, visible width in pixels.
REQ-003 The block SHALL have parameter VACTIVE, default 600, visible height in pixels.
REQ-004 The block SHALL have parameter SPRITE_W, default 32, and SPRITE_H, default 32, sprite box size.
REQ-005 The block SHALL have parameter STEP, default 1, pixels moved per update (1..16).
REQ-006 The block SHALL have parameter DIV, default 1, frames per update (1..64).
REQ-007 clk  input  1  system clock.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 EOF  input  1  end-of-frame level from the video timing generator.
REQ-010 dir  input  [NPLAYERS][4]  per player {up, down, left, right}, level-sensitive.
REQ-011 pos_x  output  [NPLAYERS] signed 11  top-left X of each sprite.
REQ-012 pos_y  output  [NPLAYERS] signed 11  top-left Y of each sprite.
REQ-013 blocked  output  [NPLAYERS]  1 when that player's last requested move was rejected or clamped.
REQ-014 upd  output  1  one-cycle pulse, the cycle after positions change.

Function
REQ-015 tick SHALL be EOF & ~eof_q, where eof_q is EOF registered; one tick per frame regardless of EOF length.
REQ-016 A frame counter SHALL count ticks 0..DIV-1 and wrap; an update edge is the clk edge where tick=1 and counter=DIV-1.
REQ-017 Positions SHALL change only on update edges; upd SHALL be high exactly the following cycle.
REQ-018 Per axis, candidate = pos + STEP (down/right), pos - STEP (up/left), unchanged if both or neither opposing bits set.
REQ-019 Diagonal moves (one X bit plus one Y bit) SHALL apply both axes in the same update.
REQ-020 Arithmetic SHALL use 12-bit signed intermediates; no wrap-around is permitted.
REQ-021 Candidates SHALL be clamped to X in [0, HACTIVE-SPRITE_W] and Y in [0, VACTIVE-SPRITE_H].
REQ-022 blocked[i] SHALL be set on an update edge if any requested axis was clamped or rejected, else cleared; it holds between updates.
REQ-023 Direction inputs SHALL be sampled only on the update edge; changes between updates have no effect.

Reset
REQ-024 On reset, player 0 SHALL be at (0,0), player 1 at (HACTIVE-SPRITE_W, VACTIVE-SPRITE_H), player 2 at (HACTIVE-SPRITE_W, 0), player 3 at (0, VACTIVE-SPRITE_H).
REQ-025 On reset, eof_q, frame counter, blocked, and upd SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort any pending update; the first tick after release counts as counter value 0.

Configuration
REQ-027 With PLAYER_COLLISION_EN defined, a player's clamped candidate box overlapping (strict, shared edges allowed) any other player's current box or candidate box SHALL reject that player's whole move and set blocked.
REQ-028 Without PLAYER_COLLISION_EN, players SHALL move independently and may overlap.

Structure
REQ-029 Package player_pkg SHALL hold the direction bit indices, reset-corner constants, and coordinate typedef (signed 11-bit).
REQ-030 Sub-module player_step SHALL compute one player's clamped candidate and clamp flag combinationally; player_mover instantiates NPLAYERS copies.

Verification
REQ-031 Reset, default params -> pos0=(0,0), pos1=(768,568), upd=0, blocked=0.
REQ-032 dir0=right held, EOF high 3 cycles per frame for 5 frames -> pos0.x=5, exactly 5 upd pulses.
REQ-033 DIV=4, STEP=2, dir0=down for 8 frames -> pos0.y=4, upd on frames 4 and 8 only.
REQ-034 pos1 at (768,568), dir1=right+down -> position unchanged, blocked1=1; dir0=up+down -> no Y move, blocked0=0.
REQ-035 PLAYER_COLLISION_EN, pos0=(100,100), pos1=(132,100), dir0=right -> pos0 stays (100,100), blocked0=1; without macro -> pos0=(101,100).
REQ-036 reset_n pulsed low while EOF high on the update frame -> no update, positions return to reset corners.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and constants for the player movement block.
// Direction bit order matches the dir port: {up, down, left, right}.
package player_pkg;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   // Bit i set means player i starts on the right / bottom edge.
   localparam logic [3:0] CORNER_RIGHT  = 4'b0110;
   localparam logic [3:0] CORNER_BOTTOM = 4'b1010;

   typedef logic signed [10:0] coord_t;
   typedef logic signed [11:0] wide_t;

endpackage

// File: rtl/player_step.sv
// One player's next position: signed step per axis, clamped to the visible area.
// clamped flags any requested axis that hit an edge.
module player_step
   import player_pkg::*;
#(
   parameter int HACTIVE  = 800,
   parameter int VACTIVE  = 600,
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32,
   parameter int STEP     = 1
) (
   input  coord_t     pos_x,
   input  coord_t     pos_y,
   input  logic [3:0] dir,
   output coord_t     cand_x,
   output coord_t     cand_y,
   output logic       clamped
);

   localparam wide_t XMAX = wide_t'(HACTIVE - SPRITE_W);
   localparam wide_t YMAX = wide_t'(VACTIVE - SPRITE_H);

   wide_t nx, ny;
   logic  req_x, req_y, clx, cly;

   always_comb begin
      req_x = dir[DIR_RIGHT] ^ dir[DIR_LEFT];
      req_y = dir[DIR_DOWN] ^ dir[DIR_UP];
      nx    = wide_t'(pos_x);
      ny    = wide_t'(pos_y);
      if (req_x) nx = dir[DIR_RIGHT] ? nx + wide_t'(STEP) : nx - wide_t'(STEP);
      if (req_y) ny = dir[DIR_DOWN]  ? ny + wide_t'(STEP) : ny - wide_t'(STEP);

      clx    = 1'b0;
      cly    = 1'b0;
      cand_x = coord_t'(nx);
      cand_y = coord_t'(ny);
      if (nx < 0) begin
         cand_x = '0;
         clx    = 1'b1;
      end else if (nx > XMAX) begin
         cand_x = coord_t'(XMAX);
         clx    = 1'b1;
      end
      if (ny < 0) begin
         cand_y = '0;
         cly    = 1'b1;
      end else if (ny > YMAX) begin
         cand_y = coord_t'(YMAX);
         cly    = 1'b1;
      end
      clamped = clx | cly;
   end

endmodule

// File: rtl/player_mover.sv
// Moves NPLAYERS sprites once every DIV frames from level-sensitive direction inputs.
// Define PLAYER_COLLISION_EN to reject moves whose box would overlap another player.
module player_mover
   import player_pkg::*;
#(
   parameter int NPLAYERS = 2,
   parameter int HACTIVE  = 800,
   parameter int VACTIVE  = 600,
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32,
   parameter int STEP     = 1,
   parameter int DIV      = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      EOF,
   input  logic [NPLAYERS-1:0][3:0]  dir,
   output coord_t [NPLAYERS-1:0]     pos_x,
   output coord_t [NPLAYERS-1:0]     pos_y,
   output logic [NPLAYERS-1:0]       blocked,
   output logic                      upd
);

   localparam int     CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam coord_t XMAX = coord_t'(HACTIVE - SPRITE_W);
   localparam coord_t YMAX = coord_t'(VACTIVE - SPRITE_H);

   logic          eof_q, tick, upd_edge;
   logic [CW-1:0] cnt;

   coord_t [NPLAYERS-1:0] cand_x, cand_y;
   logic   [NPLAYERS-1:0] clamped, reject;

   assign tick     = EOF & ~eof_q;
   assign upd_edge = tick && (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eof_q <= 1'b0;
         cnt   <= '0;
         upd   <= 1'b0;
      end else begin
         eof_q <= EOF;
         upd   <= upd_edge;
         if (tick) cnt <= upd_edge ? '0 : cnt + CW'(1);
      end
   end

   for (genvar i = 0; i < NPLAYERS; i++) begin : g_player
      player_step #(
         .HACTIVE (HACTIVE),
         .VACTIVE (VACTIVE),
         .SPRITE_W(SPRITE_W),
         .SPRITE_H(SPRITE_H),
         .STEP    (STEP)
      ) u_step (
         .pos_x  (pos_x[i]),
         .pos_y  (pos_y[i]),
         .dir    (dir[i]),
         .cand_x (cand_x[i]),
         .cand_y (cand_y[i]),
         .clamped(clamped[i])
      );

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pos_x[i]   <= CORNER_RIGHT[i]  ? XMAX : '0;
            pos_y[i]   <= CORNER_BOTTOM[i] ? YMAX : '0;
            blocked[i] <= 1'b0;
         end else if (upd_edge) begin
            if (!reject[i]) begin
               pos_x[i] <= cand_x[i];
               pos_y[i] <= cand_y[i];
            end
            blocked[i] <= clamped[i] | reject[i];
         end
      end
   end

`ifdef PLAYER_COLLISION_EN
   function automatic logic overlap(int ax, int ay, int bx, int by);
      return (ax < bx + SPRITE_W) && (bx < ax + SPRITE_W) &&
             (ay < by + SPRITE_H) && (by < ay + SPRITE_H);
   endfunction

   // A stationary player has no move to reject, so it never picks up blocked here.
   always_comb begin
      reject = '0;
      for (int i = 0; i < NPLAYERS; i++) begin
         for (int j = 0; j < NPLAYERS; j++) begin
            if (i != j && ((cand_x[i] != pos_x[i]) || (cand_y[i] != pos_y[i]))) begin
               if (overlap(int'($signed(cand_x[i])), int'($signed(cand_y[i])),
                           int'($signed(pos_x[j])),  int'($signed(pos_y[j]))) ||
                   overlap(int'($signed(cand_x[i])), int'($signed(cand_y[i])),
                           int'($signed(cand_x[j])), int'($signed(cand_y[j]))))
                  reject[i] = 1'b1;
            end
         end
      end
   end
`else
   assign reject = '0;
`endif

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: a default instance and a DIV=4/STEP=2 instance.
// Expected positions are queued per update frame and checked whenever upd pulses.
module tb_player_mover;

   typedef struct {
      int x0, y0, x1, y1, blk;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic eof_a = 1'b0, eof_b = 1'b0;
   logic [1:0][3:0]  dir_a = '0, dir_b = '0;
   logic [1:0][10:0] pxa, pya, pxb, pyb;
   logic [1:0]       blka, blkb;
   logic             upda, updb;

   int n_chk = 0, n_pass = 0, n_upd_a = 0, n_upd_b = 0;
   exp_t qa[$], qb[$];
   exp_t ea, eb;

   always #5 clk = ~clk;

   player_mover dut_a (
      .clk(clk), .reset_n(reset_n), .EOF(eof_a), .dir(dir_a),
      .pos_x(pxa), .pos_y(pya), .blocked(blka), .upd(upda)
   );

   player_mover #(.NPLAYERS(2), .STEP(2), .DIV(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .EOF(eof_b), .dir(dir_b),
      .pos_x(pxb), .pos_y(pyb), .blocked(blkb), .upd(updb)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   function automatic exp_t mk(int x0, int y0, int x1, int y1, int blk);
      exp_t e;
      e.x0 = x0; e.y0 = y0; e.x1 = x1; e.y1 = y1; e.blk = blk;
      return e;
   endfunction

   task automatic cmp(input string tag, input exp_t e, input logic [1:0][10:0] px,
                      input logic [1:0][10:0] py, input logic [1:0] blk);
      chk({tag, "_x0"}, int'($signed(px[0])), e.x0);
      chk({tag, "_y0"}, int'($signed(py[0])), e.y0);
      chk({tag, "_x1"}, int'($signed(px[1])), e.x1);
      chk({tag, "_y1"}, int'($signed(py[1])), e.y1);
      chk({tag, "_blocked"}, int'(blk), e.blk);
   endtask

   // Monitors: every upd pulse must correspond to a queued expectation.
   always @(negedge clk) begin
      if (reset_n && upda) begin
         n_upd_a++;
         if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL a_upd_unexpected: upd=1, want 0 (no update due)");
         end else begin
            ea = qa.pop_front();
            cmp("a", ea, pxa, pya, blka);
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && updb) begin
         n_upd_b++;
         if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL b_upd_unexpected: upd=1, want 0 (no update due)");
         end else begin
            eb = qb.pop_front();
            cmp("b", eb, pxb, pyb, blkb);
         end
      end
   end

   // One frame: EOF high for hi cycles then low for 3; the update (if due) is queued first.
   task automatic frame(input bit sel_b, input int hi, input bit exp_upd, input exp_t e);
      if (exp_upd) begin
         if (sel_b) qb.push_back(e);
         else       qa.push_back(e);
      end
      if (sel_b) eof_b = 1'b1;
      else       eof_a = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      eof_a = 1'b0;
      eof_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_corners();
      chk("rst_a_x0", int'($signed(pxa[0])), 0);
      chk("rst_a_y0", int'($signed(pya[0])), 0);
      chk("rst_a_x1", int'($signed(pxa[1])), 768);
      chk("rst_a_y1", int'($signed(pya[1])), 568);
      chk("rst_a_blocked", int'(blka), 0);
      chk("rst_a_upd", int'(upda), 0);
      chk("rst_b_x0", int'($signed(pxb[0])), 0);
      chk("rst_b_y0", int'($signed(pyb[0])), 0);
      chk("rst_b_x1", int'($signed(pxb[1])), 768);
      chk("rst_b_y1", int'($signed(pyb[1])), 568);
      chk("rst_b_upd", int'(updb), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int x0, y0;
      repeat (3) @(posedge clk);
      #1;
      check_corners();
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Rightward walk with a 3-cycle EOF: one step per frame.
      dir_a[0] = 4'b0001;
      for (int k = 1; k <= 5; k++) frame(1'b0, 3, 1'b1, mk(k, 0, 768, 568, 0));
      chk("a_upd_count_5", n_upd_a, 5);
      chk("a_x0_after_5", int'($signed(pxa[0])), 5);

      // Direction changes between updates are ignored.
      dir_a[0] = 4'b0000;
      frame(1'b0, 2, 1'b1, mk(5, 0, 768, 568, 0));
      dir_a[0] = 4'b0010;
      repeat (2) @(posedge clk);
      #1;
      dir_a[0] = 4'b0000;
      frame(1'b0, 2, 1'b1, mk(5, 0, 768, 568, 0));

      // Corner clamp on player 1; opposing bits on player 0 cancel without blocking.
      dir_a[0] = 4'b1100;
      dir_a[1] = 4'b0101;
      frame(1'b0, 1, 1'b1, mk(5, 0, 768, 568, 2));
      dir_a[0] = 4'b1000;
      dir_a[1] = 4'b0000;
      frame(1'b0, 1, 1'b1, mk(5, 0, 768, 568, 1));

      // Walk player 0 to (100,100) and player 1 to (132,100).
      for (int k = 1; k <= 636; k++) begin
         dir_a[0] = (k <= 95) ? 4'b0101 : (k <= 100) ? 4'b0100 : 4'b0000;
         dir_a[1] = (k <= 468) ? 4'b1010 : 4'b0010;
         x0 = (k <= 95) ? 5 + k : 100;
         y0 = (k <= 100) ? k : 100;
         frame(1'b0, 1, 1'b1, mk(x0, y0, 768 - k, (k <= 468) ? 568 - k : 100, 0));
      end

      // Player 0 steps right into player 1's box.
      dir_a[0] = 4'b0001;
      dir_a[1] = 4'b0000;
`ifdef PLAYER_COLLISION_EN
      frame(1'b0, 1, 1'b1, mk(100, 100, 132, 100, 1));
`else
      frame(1'b0, 1, 1'b1, mk(101, 100, 132, 100, 0));
`endif
      dir_a[0] = 4'b0000;

      // DIV=4, STEP=2: updates on frames 4 and 8 only.
      dir_b[0] = 4'b0100;
      for (int k = 1; k <= 8; k++)
         frame(1'b1, 2, (k % 4) == 0, mk(0, (k / 4) * 2, 768, 568, 0));
      chk("b_upd_count_2", n_upd_b, 2);
      chk("b_y0_after_8", int'($signed(pyb[0])), 4);

      // Reset pulse during the EOF of the fourth (update) frame aborts it.
      for (int k = 1; k <= 3; k++) frame(1'b1, 2, 1'b0, mk(0, 0, 0, 0, 0));
      reset_n = 1'b0;
      eof_b   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_corners();
      reset_n = 1'b1;
      eof_b   = 1'b0;
      @(posedge clk);
      #1;
      chk("b_upd_count_after_rst", n_upd_b, 2);
      for (int k = 1; k <= 4; k++)
         frame(1'b1, 2, k == 4, mk(0, 2, 768, 568, 0));
      chk("b_upd_count_final", n_upd_b, 3);

      repeat (3) @(posedge clk);
      #1;
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
